bp_trace_player: RTL and testbench
==================================

Name: bp_trace_player

Overview:
- Stimulus and scoring engine on the opposite side of the perceptron predictor interface (clk, b_addr, b_taken, prediction).
- Buffers a branch trace loaded over a valid/ready port, then replays it into the predictor at one branch per cycle.
- Compares each returned prediction against the recorded outcome and accumulates branch and mispredict counts.
- Sits beside bp_top in the testbench top level and in FPGA evaluation builds.

Parameters:
- ADDR_WID, `ADDR_WID, branch address width; must match bp_top.
- TRACE_DEPTH, 1024, trace buffer entries; must be a power of 2.
- PRED_LATENCY, 0, cycles from b_addr driven to prediction valid; legal range 0..3.
- CNT_WID, 32, width of the statistic counters.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- wr_valid  input  1  trace entry offered
- wr_ready  output  1  trace entry accepted when wr_valid and wr_ready are both high
- wr_addr  input  ADDR_WID  trace branch address
- wr_taken  input  1  trace branch outcome
- clear  input  1  empty the trace buffer; honoured in IDLE only
- start  input  1  begin replay; honoured in IDLE only
- b_addr  output  ADDR_WID  to predictor b_addr
- b_taken  output  1  to predictor b_taken
- b_valid  output  1  high on cycles carrying a real trace branch; predictor update enable
- prediction  input  1  from predictor
- busy  output  1  high in RUN or DRAIN
- done  output  1  one-cycle pulse at the end of a replay
- branch_count  output  CNT_WID  predictions scored in the last or current replay
- mispredict_count  output  CNT_WID  scored predictions with prediction != recorded taken

Behaviour:
- Reset values: FSM=IDLE, entry count=0, read pointer=0, b_addr=0, b_taken=0, b_valid=0, busy=0, done=0, both counters=0, latency pipe cleared. wr_ready follows from state and count (1 after reset).
- Storage: TRACE_DEPTH x (ADDR_WID+1) buffer. Entry count width is $clog2(TRACE_DEPTH)+1.
- wr_ready = (state==IDLE) && (count<TRACE_DEPTH) && !clear && !start. A write stores at index count and increments count.
- A write presented while the buffer is full is not accepted; the source holds it.
- clear in IDLE: count<=0 next cycle; counters are not affected.
- start in IDLE with count==0: go directly to DONE; done pulses; counters are zeroed.
- start in IDLE with count>0: counters zeroed, read pointer=0, go to RUN.
- start and clear asserted in the same IDLE cycle: start wins; clear is ignored.
- RUN, one entry per cycle:
  - b_addr/b_taken are registered from buffer[ptr]; b_valid=1.
  - After entry count-1, go to DRAIN; b_valid=0 and b_addr/b_taken hold their last values.
- Scoring:
  - The expected outcome travels through a PRED_LATENCY-deep shift register, with a valid bit, aligned to the cycle b_addr is presented.
  - On each cycle the aligned valid bit is high, branch_count increments and mispredict_count increments when prediction != expected.
  - With PRED_LATENCY=0, prediction is sampled in the same cycle b_addr is driven.
- DRAIN: lasts exactly PRED_LATENCY cycles (0 means skip straight to DONE), then DONE.
- DONE: done=1 for one cycle, then IDLE.
  - Counters hold their values until the next start.
  - The buffer contents are retained, so a second start replays the same trace; this is how predictor warm-up is measured.
- Counters saturate at all-ones; they never wrap.
- start, clear and wr_valid are ignored outside IDLE.
- rst mid-RUN: everything returns to reset values on the next edge, including count=0, so the trace is lost.
- Total replay time: count + PRED_LATENCY + 1 cycles from the cycle after start to done.

Decomposition:
- Shared package bp_pkg:
  - trace_entry_t struct {addr, taken}
  - player state enum {IDLE, RUN, DRAIN, DONE}
  - localparam PTR_WID = $clog2(TRACE_DEPTH)
- Sub-module bp_trace_mem: a simple-dual-port synchronous RAM (one write port, one registered read port) so that synthesis infers block RAM.
  - The player issues reads one cycle ahead to absorb the read latency.

Test Plan:
- Load 4 entries (0x10 T, 0x20 N, 0x10 T, 0x20 N), start, with prediction forced to 1 -> b_valid high exactly 4 cycles, b_addr sequence 0x10,0x20,0x10,0x20, branch_count=4, mispredict_count=2, done pulses once, 5 cycles after the cycle following start.
- Start with empty buffer -> done pulses the next cycle, busy never high, both counters 0.
- Fill to TRACE_DEPTH=1024 -> wr_ready drops after entry 1024; a 1025th wr_valid is held and not accepted; replay scores branch_count=1024.
- PRED_LATENCY=2, 3 entries, prediction = b_taken delayed by 2 cycles -> mispredict_count=0, branch_count=3, DRAIN lasts 2 cycles.
- Assert rst on the second RUN cycle of a 10-entry trace -> next cycle all outputs at reset values, wr_ready=1; a following start gives an immediate done with counts 0.
- Start twice on the same 8-entry trace with the real bp_top connected -> second-run mispredict_count <= first-run mispredict_count; start and clear together in IDLE -> replay begins, buffer kept.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the branch-trace player: trace entry layout and FSM state encoding.
`ifndef ADDR_WID
`define ADDR_WID 32
`endif

package bp_pkg;

  localparam int TRACE_DEPTH_DFLT = 1024;
  localparam int PTR_WID          = $clog2(TRACE_DEPTH_DFLT);

  typedef struct packed {
    logic [`ADDR_WID-1:0] addr;
    logic                 taken;
  } trace_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } player_state_e;

endpackage

// File: rtl/bp_trace_mem.sv
// Simple-dual-port trace RAM: one write port, one registered read port (block-RAM friendly).
module bp_trace_mem #(
  parameter int DEPTH = 1024,
  parameter int WID   = 33,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           i_wr_en,
  input  logic [AW-1:0]  i_wr_addr,
  input  logic [WID-1:0] i_wr_data,
  input  logic [AW-1:0]  i_rd_addr,
  output logic [WID-1:0] o_rd_data
);

  logic [WID-1:0] r_mem [DEPTH];

  // No reset on the array or read register so the tools map this onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/bp_trace_player.sv
// Loads a branch trace, replays it into a predictor one branch per cycle and scores predictions.
// wr port handshake: an entry transfers on a clock edge where wr_valid and wr_ready are both high.
module bp_trace_player
  import bp_pkg::*;
#(
  parameter int ADDR_WID     = `ADDR_WID,
  parameter int TRACE_DEPTH  = 1024,
  parameter int PRED_LATENCY = 0,
  parameter int CNT_WID      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [ADDR_WID-1:0] wr_addr,
  input  logic                wr_taken,
  input  logic                clear,
  input  logic                start,
  output logic [ADDR_WID-1:0] b_addr,
  output logic                b_taken,
  output logic                b_valid,
  input  logic                prediction,
  output logic                busy,
  output logic                done,
  output logic [CNT_WID-1:0]  branch_count,
  output logic [CNT_WID-1:0]  mispredict_count,
  output player_state_e       dbg_state
);

  localparam int P_WID = $clog2(TRACE_DEPTH);
  localparam int C_WID = P_WID + 1;
  localparam int E_WID = ADDR_WID + 1;
  localparam logic [C_WID-1:0] DEPTH_C    = C_WID'(TRACE_DEPTH);
  localparam logic [1:0]       DRAIN_INIT = 2'((PRED_LATENCY == 0) ? 0 : PRED_LATENCY - 1);

  player_state_e       r_state, w_state_nxt;
  logic [C_WID-1:0]    r_count, r_ptr;
  logic                r_rd_vld;
  logic [1:0]          r_dcnt;
  logic [ADDR_WID-1:0] r_b_addr;
  logic                r_b_taken, r_b_valid, r_busy, r_done;
  logic [CNT_WID-1:0]  r_br_cnt, r_mis_cnt;
  logic [E_WID-1:0]    w_rd_data;
  logic [P_WID-1:0]    w_rd_addr;
  logic                w_wr_en, w_score_vld, w_score_exp;

  assign wr_ready  = (r_state == IDLE) && (r_count < DEPTH_C) && !clear && !start;
  assign w_wr_en   = wr_valid && wr_ready;
  // In IDLE the RAM is pointed at entry 0 so its data is ready on the first RUN cycle.
  assign w_rd_addr = (r_state == RUN) ? r_ptr[P_WID-1:0] : '0;

  bp_trace_mem #(.DEPTH(TRACE_DEPTH), .WID(E_WID)) u_mem (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_count[P_WID-1:0]),
    .i_wr_data ({wr_addr, wr_taken}),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Expected outcome delayed so it lines up with the predictor's answer.
  generate
    if (PRED_LATENCY == 0) begin : g_nolat
      assign w_score_vld = r_b_valid;
      assign w_score_exp = r_b_taken;
    end else begin : g_lat
      logic [1:0] r_pipe [PRED_LATENCY];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < PRED_LATENCY; i++) r_pipe[i] <= '0;
        end else begin
          r_pipe[0] <= {r_b_valid, r_b_taken};
          for (int i = 1; i < PRED_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
      end
      assign w_score_vld = r_pipe[PRED_LATENCY-1][1];
      assign w_score_exp = r_pipe[PRED_LATENCY-1][0];
    end
  endgenerate

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = (r_count == '0) ? DONE : RUN;
      RUN:     if (!r_rd_vld) w_state_nxt = (PRED_LATENCY == 0) ? DONE : DRAIN;
      DRAIN:   if (r_dcnt == 2'd0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_count   <= '0;
      r_ptr     <= '0;
      r_rd_vld  <= 1'b0;
      r_dcnt    <= '0;
      r_b_addr  <= '0;
      r_b_taken <= 1'b0;
      r_b_valid <= 1'b0;
      r_br_cnt  <= '0;
      r_mis_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == RUN) || (w_state_nxt == DRAIN);
      r_done  <= (w_state_nxt == DONE);
      if (w_wr_en) r_count <= r_count + 1'b1;
      if (w_score_vld) begin
        if (~&r_br_cnt) r_br_cnt <= r_br_cnt + 1'b1;
        if ((prediction != w_score_exp) && ~&r_mis_cnt) r_mis_cnt <= r_mis_cnt + 1'b1;
      end
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
            r_ptr     <= C_WID'(1);
            r_rd_vld  <= (r_count != '0);
          end else if (clear) begin
            r_count <= '0;
          end
        end
        RUN: begin
          // r_rd_vld marks that w_rd_data holds a real entry this cycle.
          if (r_rd_vld) begin
            r_b_addr  <= w_rd_data[E_WID-1:1];
            r_b_taken <= w_rd_data[0];
          end
          r_b_valid <= r_rd_vld;
          if (r_ptr < r_count) begin
            r_ptr    <= r_ptr + 1'b1;
            r_rd_vld <= 1'b1;
          end else begin
            r_rd_vld <= 1'b0;
          end
          if (!r_rd_vld) r_dcnt <= DRAIN_INIT;
        end
        DRAIN:   r_dcnt <= r_dcnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign b_addr           = r_b_addr;
  assign b_taken          = r_b_taken;
  assign b_valid          = r_b_valid;
  assign busy             = r_busy;
  assign done             = r_done;
  assign branch_count     = r_br_cnt;
  assign mispredict_count = r_mis_cnt;
  assign dbg_state        = r_state;

endmodule

// File: tb/tb_bp_trace_player.sv
// Directed bench: a zero-latency player (u_dut0) and a 2-cycle-latency, 2-bit-counter player (u_dut2).
`timescale 1ns/1ps
module tb_bp_trace_player;
  import bp_pkg::*;

  localparam int AW  = 32;
  localparam int CW0 = 32;
  localparam int CW2 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT0 signals ----------------
  logic           s0_wr_valid, s0_wr_ready, s0_wr_taken, s0_clear, s0_start, s0_pred;
  logic [AW-1:0]  s0_wr_addr, s0_b_addr;
  logic           s0_b_taken, s0_b_valid, s0_busy, s0_done;
  logic [CW0-1:0] s0_br, s0_mis;
  player_state_e  s0_st;

  // ---------------- DUT2 signals ----------------
  logic           s2_wr_valid, s2_wr_ready, s2_wr_taken, s2_clear, s2_start, s2_pred;
  logic [AW-1:0]  s2_wr_addr, s2_b_addr;
  logic           s2_b_taken, s2_b_valid, s2_busy, s2_done;
  logic [CW2-1:0] s2_br, s2_mis;
  player_state_e  s2_st;

  // Predictor model for DUT2: answers with b_taken two cycles late, optionally inverted.
  logic p1 = 1'b0, p2 = 1'b0, s2_inv;
  always @(posedge clk) begin
    p1 <= s2_b_taken;
    p2 <= p1;
  end
  assign s2_pred = p2 ^ s2_inv;

  bp_trace_player #(.ADDR_WID(AW), .TRACE_DEPTH(1024), .PRED_LATENCY(0), .CNT_WID(CW0)) u_dut0 (
    .clk(clk), .rst(rst), .wr_valid(s0_wr_valid), .wr_ready(s0_wr_ready), .wr_addr(s0_wr_addr),
    .wr_taken(s0_wr_taken), .clear(s0_clear), .start(s0_start), .b_addr(s0_b_addr),
    .b_taken(s0_b_taken), .b_valid(s0_b_valid), .prediction(s0_pred), .busy(s0_busy),
    .done(s0_done), .branch_count(s0_br), .mispredict_count(s0_mis), .dbg_state(s0_st)
  );

  bp_trace_player #(.ADDR_WID(AW), .TRACE_DEPTH(16), .PRED_LATENCY(2), .CNT_WID(CW2)) u_dut2 (
    .clk(clk), .rst(rst), .wr_valid(s2_wr_valid), .wr_ready(s2_wr_ready), .wr_addr(s2_wr_addr),
    .wr_taken(s2_wr_taken), .clear(s2_clear), .start(s2_start), .b_addr(s2_b_addr),
    .b_taken(s2_b_taken), .b_valid(s2_b_valid), .prediction(s2_pred), .busy(s2_busy),
    .done(s2_done), .branch_count(s2_br), .mispredict_count(s2_mis), .dbg_state(s2_st)
  );

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // All tasks start and end just after a falling edge.
  task automatic load(input bit sel, input logic [AW-1:0] a, input bit t);
    bit acc = 1'b0;
    bit rdy;
    if (sel) begin s2_wr_valid = 1'b1; s2_wr_addr = a; s2_wr_taken = t; end
    else     begin s0_wr_valid = 1'b1; s0_wr_addr = a; s0_wr_taken = t; end
    for (int w = 0; w < 50 && !acc; w++) begin
      #1;
      rdy = sel ? s2_wr_ready : s0_wr_ready;
      @(posedge clk);
      if (rdy) acc = 1'b1;
      @(negedge clk);
    end
    s0_wr_valid = 1'b0;
    s2_wr_valid = 1'b0;
    if (!acc) chk("load_timeout", 64'd0, 64'd1);
  endtask

  task automatic pulse_clear(input bit sel);
    if (sel) s2_clear = 1'b1; else s0_clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s0_clear = 1'b0;
    s2_clear = 1'b0;
  endtask

  int nvalid, done_at, ndone, busy_cyc, drain_cyc;

  // Pulses start (optionally with clear) and watches the replay; cycle 0 is the cycle after start.
  task automatic replay(input bit sel, input bit with_clear, input int budget);
    logic [AW-1:0] e;
    nvalid = 0; done_at = -1; ndone = 0; busy_cyc = 0; drain_cyc = 0;
    if (sel) s2_start = 1'b1;
    else begin s0_start = 1'b1; s0_clear = with_clear; end
    @(posedge clk);
    #1;
    s0_start = 1'b0; s0_clear = 1'b0; s2_start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (sel ? s2_b_valid : s0_b_valid) begin
        nvalid++;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("b_addr_seq", sel ? s2_b_addr : s0_b_addr, e);
        end else begin
          chk("b_valid_extra", 64'd1, 64'd0);
        end
      end
      if (sel ? s2_busy : s0_busy) busy_cyc++;
      if ((sel ? s2_st : s0_st) == DRAIN) drain_cyc++;
      if (sel ? s2_done : s0_done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (done_at >= 0 && c >= done_at + 2) break;
    end
    chk("done_pulses", ndone, 1);
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_wr_ready"}, s0_wr_ready, 1);
    chk({tag, "_b_addr"},   s0_b_addr, 0);
    chk({tag, "_b_taken"},  s0_b_taken, 0);
    chk({tag, "_b_valid"},  s0_b_valid, 0);
    chk({tag, "_busy"},     s0_busy, 0);
    chk({tag, "_done"},     s0_done, 0);
    chk({tag, "_br"},       s0_br, 0);
    chk({tag, "_mis"},      s0_mis, 0);
    chk({tag, "_state"},    s0_st, IDLE);
  endtask

  typedef struct {
    logic [AW-1:0] addr;
    bit            taken;
    logic [AW-1:0] exp_addr;
    bit            exp_mis;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int   exp_mis;

    tbl[0] = '{32'h10, 1'b1, 32'h10, 1'b0};
    tbl[1] = '{32'h20, 1'b0, 32'h20, 1'b1};
    tbl[2] = '{32'h10, 1'b1, 32'h10, 1'b0};
    tbl[3] = '{32'h20, 1'b0, 32'h20, 1'b1};

    rst = 1'b1;
    s0_wr_valid = 0; s0_wr_addr = '0; s0_wr_taken = 0; s0_clear = 0; s0_start = 0; s0_pred = 1'b1;
    s2_wr_valid = 0; s2_wr_addr = '0; s2_wr_taken = 0; s2_clear = 0; s2_start = 0; s2_inv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset0("rst");
    chk("rst2_wr_ready", s2_wr_ready, 1);
    chk("rst2_br", s2_br, 0);
    rst = 1'b0;
    @(negedge clk);

    // Empty buffer: done the very next cycle, never busy.
    replay(1'b0, 1'b0, 20);
    chk("empty_done_at", done_at, 0);
    chk("empty_busy", busy_cyc, 0);
    chk("empty_br", s0_br, 0);
    chk("empty_mis", s0_mis, 0);

    // Table-driven 4-entry trace with prediction stuck at taken.
    exp_mis = 0;
    for (int i = 0; i < 4; i++) begin
      load(1'b0, tbl[i].addr, tbl[i].taken);
      exp_q.push_back(tbl[i].exp_addr);
      exp_mis += int'(tbl[i].exp_mis);
    end
    replay(1'b0, 1'b0, 40);
    chk("t4_nvalid", nvalid, 4);
    chk("t4_done_at", done_at, 5);
    chk("t4_busy", busy_cyc, 5);
    chk("t4_br", s0_br, 4);
    chk("t4_mis", s0_mis, exp_mis);
    chk("t4_b_addr_hold", s0_b_addr, 32'h20);

    // Fill to capacity; the next offer must be held off.
    pulse_clear(1'b0);
    for (int i = 0; i < 1024; i++) begin
      load(1'b0, 32'h1000 + 32'(i * 4), i[0]);
      exp_q.push_back(32'h1000 + 32'(i * 4));
    end
    s0_wr_valid = 1'b1; s0_wr_addr = 32'hdead; s0_wr_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("full_wr_ready", s0_wr_ready, 0);
      @(negedge clk);
    end
    s0_wr_valid = 1'b0;
    replay(1'b0, 1'b0, 1100);
    chk("full_nvalid", nvalid, 1024);
    chk("full_done_at", done_at, 1025);
    chk("full_br", s0_br, 1024);
    chk("full_mis", s0_mis, 512);

    // Replay retention, start+clear together, then clear on its own.
    pulse_clear(1'b0);
    for (int i = 0; i < 8; i++) begin
      load(1'b0, 32'h100 + 32'(i), (i % 3) == 0);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(i));
    replay(1'b0, 1'b0, 40);
    chk("r8a_br", s0_br, 8);
    chk("r8a_mis", s0_mis, 5);
    s0_pred = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(32'h100 + 32'(i));
    replay(1'b0, 1'b1, 40);
    chk("r8b_nvalid", nvalid, 8);
    chk("r8b_done_at", done_at, 9);
    chk("r8b_br", s0_br, 8);
    chk("r8b_mis", s0_mis, 3);
    pulse_clear(1'b0);
    chk("clr_keeps_br", s0_br, 8);
    chk("clr_keeps_mis", s0_mis, 3);
    replay(1'b0, 1'b0, 20);
    chk("clr_done_at", done_at, 0);
    chk("clr_nvalid", nvalid, 0);
    chk("clr_br", s0_br, 0);
    s0_pred = 1'b1;

    // Latency-2 player: aligned predictor gives zero mispredicts, DRAIN lasts two cycles.
    load(1'b1, 32'h0a, 1'b1);
    load(1'b1, 32'h0b, 1'b0);
    load(1'b1, 32'h0c, 1'b1);
    exp_q.push_back(32'h0a); exp_q.push_back(32'h0b); exp_q.push_back(32'h0c);
    replay(1'b1, 1'b0, 40);
    chk("l2_nvalid", nvalid, 3);
    chk("l2_done_at", done_at, 6);
    chk("l2_drain", drain_cyc, 2);
    chk("l2_br", s2_br, 3);
    chk("l2_mis", s2_mis, 0);

    // Five entries against 2-bit counters with an always-wrong predictor: both saturate at 3.
    load(1'b1, 32'h0d, 1'b0);
    load(1'b1, 32'h0e, 1'b1);
    exp_q.push_back(32'h0a); exp_q.push_back(32'h0b); exp_q.push_back(32'h0c);
    exp_q.push_back(32'h0d); exp_q.push_back(32'h0e);
    s2_inv = 1'b1;
    replay(1'b1, 1'b0, 40);
    chk("sat_nvalid", nvalid, 5);
    chk("sat_done_at", done_at, 8);
    chk("sat_br", s2_br, 3);
    chk("sat_mis", s2_mis, 3);
    s2_inv = 1'b0;

    // Reset on the second RUN cycle of a 10-entry replay loses the trace.
    pulse_clear(1'b0);
    for (int i = 0; i < 10; i++) load(1'b0, 32'h200 + 32'(i), 1'b1);
    s0_start = 1'b1;
    @(posedge clk);
    #1;
    s0_start = 1'b0;
    @(negedge clk);
    chk("mid_state_run", s0_st, RUN);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset0("midrst");
    exp_q.delete();
    replay(1'b0, 1'b0, 20);
    chk("midrst_done_at", done_at, 0);
    chk("midrst_nvalid", nvalid, 0);
    chk("midrst_br", s0_br, 0);
    chk("midrst_mis", s0_mis, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
